// File: rtl/seg_pkg.sv
// Shared constants for the 5-digit multiplexed 7-segment scanner:
// digit count, scan state encoding and the hex-to-segment table.
package seg_pkg;

  localparam int NUM_DIGITS = 5;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  // Entry [h] holds segments g..a for hex value h (entry 15 listed first).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to 7-segment pattern (bit6..0 = g..a).
module seg7_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scanner for five 7-segment digits with a per-slot dark
// interval and a shadow register that only reloads at frame boundaries.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIV   = 1000,
  parameter int BLANK = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        upd_req,
  input  logic [19:0] upd_digits,
  input  logic [4:0]  upd_blank,
  input  logic [4:0]  upd_dp,
  output logic        upd_ack,
  output logic [4:0]  SEG_SEL,
  output logic [7:0]  SEG_DATA,
  output logic        frame_start
);

  localparam int             CW       = $clog2(DIV);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0]  BLK_LAST = CW'(BLANK - 1);
  localparam logic [2:0]     IDX_LAST = 3'(NUM_DIGITS - 1);

  generate
    if (BLANK < 1 || BLANK >= DIV) begin : g_bad_param
      $error("seg_scan_ctrl: BLANK must satisfy 1 <= BLANK < DIV");
    end
  endgenerate

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  scan_state_t   r_state;
  logic [19:0]   r_digits;
  logic [4:0]    r_blank;
  logic [4:0]    r_dp;

  logic [3:0] w_nib;
  logic [6:0] w_seg;
  logic [4:0] w_onehot;
  logic       w_frame_end;

  assign w_nib       = r_digits[{r_idx, 2'b00} +: 4];
  assign w_onehot    = 5'b00001 << r_idx;
  assign w_frame_end = (r_cnt == CNT_LAST) && (r_idx == IDX_LAST);

  seg7_hex_decode u_dec (
    .i_hex (w_nib),
    .o_seg (w_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_state     <= ST_BLANK;
      r_digits    <= '0;
      r_blank     <= '1;
      r_dp        <= '0;
      upd_ack     <= 1'b0;
      SEG_SEL     <= '0;
      SEG_DATA    <= '0;
      frame_start <= 1'b0;
    end else begin
      upd_ack     <= 1'b0;
      frame_start <= (r_cnt == '0) && (r_idx == '0);

      // Outputs are a registered image of this cycle's state and index.
      if (r_state == ST_SHOW) begin
        SEG_SEL  <= w_onehot;
        SEG_DATA <= r_blank[r_idx] ? 8'h00 : {r_dp[r_idx], w_seg};
      end else begin
        SEG_SEL  <= '0;
        SEG_DATA <= '0;
      end

      if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_idx   <= (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
        r_state <= ST_BLANK;
      end else begin
        r_cnt <= r_cnt + CW'(1);
        if (r_cnt == BLK_LAST) r_state <= ST_SHOW;
      end

      // Reload only on the last cycle of a frame so a frame is never torn.
      if (w_frame_end && upd_req) begin
        r_digits <= upd_digits;
        r_blank  <= upd_blank;
        r_dp     <= upd_dp;
        upd_ack  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIV=8, BLANK=2 (40-cycle frames).
module tb_seg_scan_ctrl;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 5 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        upd_req = 1'b0;
  logic [19:0] upd_digits = '0;
  logic [4:0]  upd_blank = '0;
  logic [4:0]  upd_dp = '0;
  logic        upd_ack;
  logic [4:0]  SEG_SEL;
  logic [7:0]  SEG_DATA;
  logic        frame_start;

  int total = 0;
  int bad   = 0;
  int n     = 0;

  seg_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .upd_req     (upd_req),
    .upd_digits  (upd_digits),
    .upd_blank   (upd_blank),
    .upd_dp      (upd_dp),
    .upd_ack     (upd_ack),
    .SEG_SEL     (SEG_SEL),
    .SEG_DATA    (SEG_DATA),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // n = number of rising edges since reset release; outputs after edge n
  // reflect counter (n-1)%DIV and digit ((n-1)/DIV)%5.
  function automatic logic [4:0] f_sel(int cyc);
    int c, i;
    c = (cyc - 1) % DIV;
    i = ((cyc - 1) / DIV) % 5;
    return (c < BLANK) ? 5'b00000 : (5'b00001 << i);
  endfunction

  function automatic logic [7:0] f_data(int cyc, logic [4:0][7:0] seg);
    int c, i;
    c = (cyc - 1) % DIV;
    i = ((cyc - 1) / DIV) % 5;
    return (c < BLANK) ? 8'h00 : seg[i];
  endfunction

  function automatic logic f_fs(int cyc);
    return ((cyc - 1) % FRAME) == 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    n++;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    upd_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    upd_req    = 1'b1;
    upd_digits = 20'h12345;
    repeat (3) @(negedge clk);
    total += 4;
    if (SEG_SEL !== 5'b0) begin bad++; $display("FAIL rst_sel got=%b exp=00000", SEG_SEL); end
    if (SEG_DATA !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", SEG_DATA); end
    if (upd_ack !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b exp=0", upd_ack); end
    if (frame_start !== 1'b0) begin bad++; $display("FAIL rst_fs got=%b exp=0", frame_start); end
    upd_req = 1'b0;
  endtask

  task automatic test_idle_scan();
    do_reset();
    for (int k = 0; k < 2 * FRAME; k++) begin
      tick();
      total += 4;
      if (SEG_SEL !== f_sel(n)) begin bad++; $display("FAIL idle_sel n=%0d got=%b exp=%b", n, SEG_SEL, f_sel(n)); end
      if (SEG_DATA !== 8'h00) begin bad++; $display("FAIL idle_data n=%0d got=%h exp=00", n, SEG_DATA); end
      if (frame_start !== f_fs(n)) begin bad++; $display("FAIL idle_fs n=%0d got=%b exp=%b", n, frame_start, f_fs(n)); end
      if (upd_ack !== 1'b0) begin bad++; $display("FAIL idle_ack n=%0d got=%b exp=0", n, upd_ack); end
    end
  endtask

  task automatic test_update();
    logic [19:0]      vals [4];
    logic [4:0][7:0]  ef   [6];
    logic             exp_ack;
    int               f;
    vals[0] = 20'h43210; vals[1] = 20'h98765; vals[2] = 20'hEDCBA; vals[3] = 20'h0000F;
    ef[0] = '0;
    ef[1] = {8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F};
    ef[2] = {8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D};
    ef[3] = {8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77};
    ef[4] = {8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h71};
    ef[5] = ef[4];
    do_reset();
    upd_blank = 5'b0;
    upd_dp    = 5'b0;
    for (int k = 0; k < 6 * FRAME; k++) begin
      if (n == 2) begin upd_digits = vals[0]; upd_req = 1'b1; end
      tick();
      f = (n - 1) / FRAME;
      exp_ack = (n % FRAME == 0) && (n >= FRAME) && (n <= 4 * FRAME);
      total += 4;
      if (upd_ack !== exp_ack) begin bad++; $display("FAIL upd_ack n=%0d got=%b exp=%b", n, upd_ack, exp_ack); end
      if (SEG_SEL !== f_sel(n)) begin bad++; $display("FAIL upd_sel n=%0d got=%b exp=%b", n, SEG_SEL, f_sel(n)); end
      if (SEG_DATA !== f_data(n, ef[f])) begin bad++; $display("FAIL upd_data n=%0d got=%h exp=%h", n, SEG_DATA, f_data(n, ef[f])); end
      if (frame_start !== f_fs(n)) begin bad++; $display("FAIL upd_fs n=%0d got=%b exp=%b", n, frame_start, f_fs(n)); end
      if (n == FRAME)     upd_digits = vals[1];
      if (n == 2 * FRAME) upd_digits = vals[2];
      if (n == 3 * FRAME) upd_digits = vals[3];
      if (n == 4 * FRAME) upd_req = 1'b0;
    end
  endtask

  task automatic test_dp_blank();
    logic [4:0][7:0] ef [3];
    logic            exp_ack;
    int              f;
    ef[0] = '0;
    ef[1] = {8'h66, 8'h4F, 8'hF7, 8'h06, 8'h3F};
    ef[2] = {8'h00, 8'h4F, 8'h5B, 8'h06, 8'h00};
    do_reset();
    upd_digits = 20'h43A10;
    upd_dp     = 5'b00100;
    upd_blank  = 5'b00000;
    upd_req    = 1'b1;
    for (int k = 0; k < 3 * FRAME; k++) begin
      tick();
      f = (n - 1) / FRAME;
      exp_ack = (n == FRAME) || (n == 2 * FRAME);
      total += 3;
      if (upd_ack !== exp_ack) begin bad++; $display("FAIL dpbl_ack n=%0d got=%b exp=%b", n, upd_ack, exp_ack); end
      if (SEG_SEL !== f_sel(n)) begin bad++; $display("FAIL dpbl_sel n=%0d got=%b exp=%b", n, SEG_SEL, f_sel(n)); end
      if (SEG_DATA !== f_data(n, ef[f])) begin bad++; $display("FAIL dpbl_data n=%0d got=%h exp=%h", n, SEG_DATA, f_data(n, ef[f])); end
      if (n == FRAME) begin
        upd_digits = 20'h43210;
        upd_dp     = 5'b00000;
        upd_blank  = 5'b10001;
      end
      if (n == 2 * FRAME) upd_req = 1'b0;
    end
  endtask

  task automatic test_late_req();
    logic [4:0][7:0] ef [2];
    logic            exp_ack;
    int              f;
    ef[0] = '0;
    ef[1] = {8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66};
    do_reset();
    upd_dp    = 5'b0;
    upd_blank = 5'b0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      // Request first appears in the counter=7, digit=4 cycle.
      if (n == FRAME - 1) begin upd_digits = 20'h01234; upd_req = 1'b1; end
      tick();
      f = (n - 1) / FRAME;
      exp_ack = (n == FRAME);
      total += 3;
      if (upd_ack !== exp_ack) begin bad++; $display("FAIL late_ack n=%0d got=%b exp=%b", n, upd_ack, exp_ack); end
      if (SEG_SEL !== f_sel(n)) begin bad++; $display("FAIL late_sel n=%0d got=%b exp=%b", n, SEG_SEL, f_sel(n)); end
      if (SEG_DATA !== f_data(n, ef[f])) begin bad++; $display("FAIL late_data n=%0d got=%h exp=%h", n, SEG_DATA, f_data(n, ef[f])); end
      if (n == FRAME) upd_req = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    upd_digits = 20'h43210;
    upd_dp     = 5'b0;
    upd_blank  = 5'b0;
    upd_req    = 1'b1;
    repeat (60) tick();
    total += 2;
    if (SEG_SEL !== 5'b00100) begin bad++; $display("FAIL mid_sel_pre got=%b exp=00100", SEG_SEL); end
    if (SEG_DATA !== 8'h5B) begin bad++; $display("FAIL mid_data_pre got=%h exp=5B", SEG_DATA); end
    #2 rst_n = 1'b0;
    #1;
    total += 3;
    if (SEG_SEL !== 5'b0) begin bad++; $display("FAIL mid_sel_async got=%b exp=00000", SEG_SEL); end
    if (SEG_DATA !== 8'h00) begin bad++; $display("FAIL mid_data_async got=%h exp=00", SEG_DATA); end
    if (upd_ack !== 1'b0) begin bad++; $display("FAIL mid_ack_async got=%b exp=0", upd_ack); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (upd_ack !== 1'b0) begin bad++; $display("FAIL mid_ack_rst k=%0d got=%b exp=0", k, upd_ack); end
    end
    upd_req = 1'b0;
    rst_n   = 1'b1;
    n       = 0;
    for (int k = 0; k < FRAME; k++) begin
      tick();
      total += 4;
      if (SEG_SEL !== f_sel(n)) begin bad++; $display("FAIL post_sel n=%0d got=%b exp=%b", n, SEG_SEL, f_sel(n)); end
      if (SEG_DATA !== 8'h00) begin bad++; $display("FAIL post_data n=%0d got=%h exp=00", n, SEG_DATA); end
      if (upd_ack !== 1'b0) begin bad++; $display("FAIL post_ack n=%0d got=%b exp=0", n, upd_ack); end
      if (frame_start !== f_fs(n)) begin bad++; $display("FAIL post_fs n=%0d got=%b exp=%b", n, frame_start, f_fs(n)); end
    end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_update();
    test_dp_blank();
    test_late_req();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
